// File: rtl/reg_file_onehot.sv
// Architectural register file with a one-hot write strobe, two combinational read ports,
// optional write-to-read bypass, a hardwired-zero x0 and a sticky malformed-select flag.
module reg_file_onehot #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     WriteEn,
  input  logic [DEPTH-1:0]         WriteSel,
  input  logic [WIDTH-1:0]         WriteData,
  input  logic [$clog2(DEPTH)-1:0] ReadAddr1,
  input  logic [$clog2(DEPTH)-1:0] ReadAddr2,
  output logic [WIDTH-1:0]         ReadData1,
  output logic [WIDTH-1:0]         ReadData2,
  output logic                     SelError,
  output logic [15:0]              WriteCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 16;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             sel_onehot;
  logic             sel_multi;
  logic             commit;

  // Clearing the lowest set bit leaves zero exactly when at most one bit is set.
  always_comb begin
    sel_multi  = (WriteSel & (WriteSel - DEPTH'(1))) != '0;
    sel_onehot = (WriteSel != '0) && !sel_multi;
    commit     = rst_n && WriteEn && sel_onehot && !WriteSel[0];
  end

  // Storage, sticky error and commit counter; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      SelError   <= 1'b0;
      WriteCount <= '0;
    end else begin
      if (commit) begin
        for (int unsigned i = 1; i < DEPTH; i++) begin
          if (WriteSel[i]) begin
            mem[i] <= WriteData;
          end
        end
        WriteCount <= WriteCount + CW'(1);
      end
      if (WriteEn && sel_multi) begin
        SelError <= 1'b1;
      end
    end
  end

  // Read ports: x0 forced to zero, optional bypass of the write being committed.
  always_comb begin
    ReadData1 = mem[ReadAddr1];
    ReadData2 = mem[ReadAddr2];
    if (BYPASS && commit && WriteSel[ReadAddr1]) begin
      ReadData1 = WriteData;
    end
    if (BYPASS && commit && WriteSel[ReadAddr2]) begin
      ReadData2 = WriteData;
    end
    if (ReadAddr1 == AW'(0)) begin
      ReadData1 = '0;
    end
    if (ReadAddr2 == AW'(0)) begin
      ReadData2 = '0;
    end
  end

endmodule
